// File: rtl/gan_result_streamer.sv
// gan_result_streamer
//   Reader/transmitter side of the GAN result memory. A Done pulse snapshots the
//   four signed 32-bit results f1..f4. They are then sent as one framed stream over
//   valid/ready: a header beat, the data beats (f1 first, most-significant beat
//   first), and finally an XOR checksum of the data beats.
// Ports
//   Clock        rising-edge system clock
//   Reset        synchronous, active-high reset
//   Done         one-cycle pulse, f1..f4 valid in that cycle
//   f1..f4       signed 32-bit results, sent raw
//   Tx_data      current beat (BEAT_W bits)
//   Tx_valid     Tx_data / Tx_last valid
//   Tx_ready     sink accepts a beat
//   Tx_last      checksum (final) beat of a frame
//   Busy         a frame is in progress
//   Overrun      sticky: a Done pulse was dropped
//   Frame_count  completed frames, wraps 255 -> 0
module gan_result_streamer #(
  parameter int unsigned       BEAT_W = 8,
  parameter logic [BEAT_W-1:0] HEADER = 'hA5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Done,
  input  logic signed [31:0] f1,
  input  logic signed [31:0] f2,
  input  logic signed [31:0] f3,
  input  logic signed [31:0] f4,
  output logic [BEAT_W-1:0]  Tx_data,
  output logic               Tx_valid,
  input  logic               Tx_ready,
  output logic               Tx_last,
  output logic               Busy,
  output logic               Overrun,
  output logic [7:0]         Frame_count
);

  localparam int unsigned BPR    = 32 / BEAT_W;
  localparam int unsigned NBEATS = 4 * BPR;
  localparam int unsigned CW     = $clog2(NBEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_CHECK  = 2'd3;

  logic [1:0]        state;
  logic [127:0]      shadow;     // {f1,f2,f3,f4}, so beat 0 is the top slice
  logic [CW-1:0]     beat_idx;
  logic [CW-1:0]     beat_inc;
  logic [BEAT_W-1:0] csum;
  logic              xfer;
  logic              take_done;

  // Beat idx of the frame payload, most-significant slice first.
  function automatic logic [BEAT_W-1:0] slice_of(input logic [127:0] vec,
                                                 input logic [CW-1:0] idx);
    logic [127:0] sh;
    sh = vec << (int'(idx) * BEAT_W);
    return sh[127 -: BEAT_W];
  endfunction

  assign xfer      = Tx_valid && Tx_ready;
  assign beat_inc  = beat_idx + CW'(1);
  // A new frame may start from IDLE or exactly on the checksum handshake.
  assign take_done = Done && ((state == S_IDLE) || ((state == S_CHECK) && xfer));
  // Tx_valid is high in every non-IDLE state, so it doubles as Busy.
  assign Busy      = Tx_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      shadow      <= '0;
      beat_idx    <= '0;
      csum        <= '0;
      Tx_data     <= '0;
      Tx_valid    <= 1'b0;
      Tx_last     <= 1'b0;
      Overrun     <= 1'b0;
      Frame_count <= '0;
    end else begin
      if (Done && !take_done)
        Overrun <= 1'b1;

      case (state)
        S_HEADER: begin
          if (xfer) begin
            Tx_data  <= slice_of(shadow, '0);
            beat_idx <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ Tx_data;
            if (beat_idx == LAST_BEAT) begin
              Tx_data <= csum ^ Tx_data;
              Tx_last <= 1'b1;
              state   <= S_CHECK;
            end else begin
              beat_idx <= beat_inc;
              Tx_data  <= slice_of(shadow, beat_inc);
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            Frame_count <= Frame_count + 8'd1;
            Tx_last     <= 1'b0;
            Tx_valid    <= 1'b0;
            Tx_data     <= '0;
            state       <= S_IDLE;
          end
        end
        default: ;
      endcase

      // Frame start is shared by IDLE and the CHECK-handshake restart; placed
      // after the case so it overrides the return-to-IDLE assignments.
      if (take_done) begin
        shadow   <= {f1, f2, f3, f4};
        csum     <= '0;
        beat_idx <= '0;
        Tx_data  <= HEADER;
        Tx_valid <= 1'b1;
        Tx_last  <= 1'b0;
        state    <= S_HEADER;
      end
    end
  end

endmodule
